// File: rtl/alu_fixed_point.sv
// Registered signed fixed-point ALU (ADD/SUB/MUL/DIV) with one-cycle latency.
// Results wrap to DATA_WIDTH bits; overflow/underflow flags are advisory.
module alu_fixed_point #(
    parameter int INT_WIDTH  = 4,
    parameter int FRAC_WIDTH = 4,
    localparam int DATA_WIDTH = INT_WIDTH + FRAC_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic        [1:0]            op,
    output logic signed [DATA_WIDTH-1:0] result,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PW = 2 * DATA_WIDTH;

    localparam logic signed [PW-1:0] MAX_W = {{(DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_W = {{(DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    op_e                         op_sel;
    logic signed [PW-1:0]        a_ext;
    logic signed [PW-1:0]        b_ext;
    logic signed [PW-1:0]        prod;
    logic signed [PW-1:0]        num;
    logic signed [PW-1:0]        den;
    logic signed [PW-1:0]        full;
    logic                        b_zero;

    logic signed [DATA_WIDTH-1:0] result_d, result_q;
    logic                         overflow_d, overflow_q;
    logic                         underflow_d, underflow_q;

    assign op_sel = op_e'(op);
    assign a_ext  = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    assign b_ext  = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    assign b_zero = (b == '0);

    // All ops are evaluated at double width so one signed range check serves every op.
    always_comb begin
        prod = a_ext * b_ext;
        num  = a_ext <<< FRAC_WIDTH;
        den  = b_ext;
        if (b_zero) begin
            den    = '0;
            den[0] = 1'b1;
        end
        full = '0;
        case (op_sel)
            OP_ADD: full = a_ext + b_ext;
            OP_SUB: full = a_ext - b_ext;
            OP_MUL: full = prod >>> FRAC_WIDTH;
            OP_DIV: full = num / den;
            default: full = '0;
        endcase
    end

    always_comb begin
        result_d    = full[DATA_WIDTH-1:0];
        overflow_d  = (full > MAX_W);
        underflow_d = (full < MIN_W);
        if (op_sel == OP_DIV && b_zero) begin
            result_d    = '0;
            overflow_d  = 1'b1;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign result    = result_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_alu_fixed_point.sv
// Bench for alu_fixed_point: integer-arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_alu_fixed_point;

    localparam int DW = 9;
    localparam int FW = 4;

    logic                 clk;
    logic                 rst;
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    logic        [1:0]    op;
    logic signed [DW-1:0] result;
    logic                 overflow;
    logic                 underflow;

    int n_checks;
    int n_fail;
    bit check_en;

    alu_fixed_point #(.INT_WIDTH(4), .FRAC_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .op        (op),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer result, floor for MUL, truncate for DIV, then wrap.
    function automatic void model(input logic signed [DW-1:0] ai, input logic signed [DW-1:0] bi,
                                  input logic [1:0] o, output logic [DW-1:0] r,
                                  output logic ov, output logic un);
        int av, bv, t, scale, maxv, minv;
        logic [31:0] tv;
        av    = ai;
        bv    = bi;
        scale = 1 << FW;
        maxv  = (1 << (DW - 1)) - 1;
        minv  = -(1 << (DW - 1));
        t     = 0;
        case (o)
            2'b00: t = av + bv;
            2'b01: t = av - bv;
            2'b10: begin
                t = av * bv;
                if (t >= 0) t = t / scale;
                else        t = -((-t + scale - 1) / scale);
            end
            default: begin
                if (bv != 0) t = (av * scale) / bv;
            end
        endcase
        tv = t;
        r  = tv[DW-1:0];
        ov = (t > maxv);
        un = (t < minv);
        if (o == 2'b11 && bv == 0) begin
            r  = '0;
            ov = 1'b1;
            un = 1'b0;
        end
    endfunction

    always @(posedge clk) begin
        logic [DW-1:0] er;
        logic eo, eu;
        if (rst) begin
            er = '0; eo = 1'b0; eu = 1'b0;
        end else begin
            model(a, b, op, er, eo, eu);
        end
        #1;
        if (check_en) begin
            n_checks++;
            if (result !== er || overflow !== eo || underflow !== eu) begin
                n_fail++;
                $display("FAIL model a=%0d b=%0d op=%0d: got res=%0d ovf=%b udf=%b, expected res=%0d ovf=%b udf=%b",
                         $signed(a), $signed(b), op, result, overflow, underflow,
                         $signed(er), eo, eu);
            end
        end
    end

    task automatic apply(input string name, input bit r, input int av, input int bv,
                         input logic [1:0] o, input int er, input bit eo, input bit eu);
        logic [31:0] ev;
        logic [DW-1:0] exp_r;
        ev    = er;
        exp_r = ev[DW-1:0];
        @(negedge clk);
        rst = r;
        a   = DW'(av);
        b   = DW'(bv);
        op  = o;
        @(posedge clk);
        #2;
        n_checks++;
        if (result !== exp_r || overflow !== eo || underflow !== eu) begin
            n_fail++;
            $display("FAIL %s: got res=%0d ovf=%b udf=%b, expected res=%0d ovf=%b udf=%b",
                     name, result, overflow, underflow, $signed(exp_r), eo, eu);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        check_en = 1'b1;
        rst = 1'b1;
        a   = 9'sd16;
        b   = 9'sd16;
        op  = 2'b00;

        apply("reset_1", 1'b1, 16, 16, 2'b00, 0, 1'b0, 1'b0);
        apply("reset_2", 1'b1, 16, 16, 2'b00, 0, 1'b0, 1'b0);
        apply("post_reset_add", 1'b0, 16, 16, 2'b00, 32, 1'b0, 1'b0);

        apply("add_1_1", 1'b0, 16, 16, 2'b00, 32, 1'b0, 1'b0);
        apply("sub_1_1", 1'b0, 16, 16, 2'b01, 0, 1'b0, 1'b0);
        apply("mul_1_1", 1'b0, 16, 16, 2'b10, 16, 1'b0, 1'b0);
        apply("div_1_1", 1'b0, 16, 16, 2'b11, 16, 1'b0, 1'b0);

        apply("add_mixed", 1'b0, 16, -8, 2'b00, 8, 1'b0, 1'b0);
        apply("sub_mixed", 1'b0, 16, -8, 2'b01, 24, 1'b0, 1'b0);
        apply("mul_mixed", 1'b0, 16, -8, 2'b10, -8, 1'b0, 1'b0);
        apply("div_mixed", 1'b0, 16, -8, 2'b11, -32, 1'b0, 1'b0);
        apply("mul_2_2", 1'b0, 32, 32, 2'b10, 64, 1'b0, 1'b0);
        apply("div_2_2", 1'b0, 32, 32, 2'b11, 16, 1'b0, 1'b0);

        apply("add_wrap", 1'b0, 255, 1, 2'b00, -256, 1'b1, 1'b0);
        apply("sub_wrap", 1'b0, -256, 1, 2'b01, 255, 1'b0, 1'b1);
        apply("mul_wrap", 1'b0, 255, 255, 2'b10, -32, 1'b1, 1'b0);
        apply("div_wrap", 1'b0, -256, -1, 2'b11, 0, 1'b1, 1'b0);

        apply("mul_floor", 1'b0, -1, 1, 2'b10, -1, 1'b0, 1'b0);
        apply("div_trunc", 1'b0, -1, 3, 2'b11, -5, 1'b0, 1'b0);
        apply("div_zero", 1'b0, 8, 0, 2'b11, 0, 1'b1, 1'b0);
        apply("div_zero_num", 1'b0, 0, 8, 2'b11, 0, 1'b0, 1'b0);

        apply("reset_mid", 1'b1, 100, 7, 2'b10, 0, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            rst = 1'b0;
            a   = DW'($urandom_range(0, (1 << DW) - 1));
            b   = DW'($urandom_range(0, (1 << DW) - 1));
            op  = 2'($urandom_range(0, 3));
        end
        @(posedge clk);
        #3;
        check_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_fixed_point.md
Name: alu_fixed_point

Overview:
Registered signed fixed-point ALU: ADD, SUB, MUL and DIV on two's-complement Q(INT_WIDTH).(FRAC_WIDTH) operands with one sign bit. It is a datapath leaf block with one clock and a synchronous active-high reset. Results are captured every cycle and are available one cycle after the operands are presented. Overflow and underflow flags report when the true result falls outside the representable range.

Parameters:
INT_WIDTH, 4, integer bits (excluding sign)
FRAC_WIDTH, 4, fractional bits
DATA_WIDTH, INT_WIDTH+FRAC_WIDTH+1 (derived localparam, 9 by default), total operand/result width incl. sign

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
a  input  DATA_WIDTH  signed operand A (raw fixed-point word)
b  input  DATA_WIDTH  signed operand B
op  input  2  00=ADD, 01=SUB, 10=MUL, 11=DIV
result  output  DATA_WIDTH  signed registered result
overflow  output  1  registered; true result > max positive (2^(DATA_WIDTH-1)-1), or divide by zero
underflow  output  1  registered; true result < min negative (-2^(DATA_WIDTH-1))

Behaviour:
- Reset: on the rising edge with rst=1, result=0, overflow=0 and underflow=0. Reset has priority over capture.
- Otherwise, on every rising edge, a, b and op are sampled and result/flags are loaded from them.
  - Latency is exactly 1 cycle. There is no handshake. Outputs hold between edges.
- All arithmetic is signed two's complement. MAX = 2^(DATA_WIDTH-1)-1 and MIN = -2^(DATA_WIDTH-1).
- ADD: the true sum is computed at DATA_WIDTH+1 bits; result = low DATA_WIDTH bits (wrap).
- SUB: the true a-b is computed at DATA_WIDTH+1 bits; result = low DATA_WIDTH bits (wrap).
- MUL:
  - p = a*b at full 2*DATA_WIDTH signed width.
  - s = p >>> FRAC_WIDTH (arithmetic shift, i.e. floor toward -inf; no rounding).
  - result = s[DATA_WIDTH-1:0].
  - Flags compare s against MAX/MIN.
- DIV, b != 0:
  - n = a sign-extended to 2*DATA_WIDTH, then <<< FRAC_WIDTH.
  - q = n / b as signed division, truncated toward zero.
  - result = q[DATA_WIDTH-1:0]. Flags compare q against MAX/MIN.
- DIV, b == 0: result = 0, overflow = 1, underflow = 0.
- Saturation is not applied: result is always the wrapped low bits. The flags are advisory only.
- overflow and underflow are never both 1.
- No X-propagation: every op code yields a defined result.

Test Plan:
- Reset:
  - rst=1 for 2 cycles with a=16, b=16, op=00 -> result=0, overflow=0, underflow=0.
  - Deassert rst -> result=32 one cycle later.
- Basic ops, a=16 (1.0), b=16:
  - ADD -> 32; SUB -> 0; MUL -> 16; DIV -> 16.
  - All flags 0, each result valid 1 cycle after the operands are applied.
- Mixed signs, a=16, b=-8:
  - ADD -> 8; SUB -> 24; MUL -> -8; DIV -> -32.
  - Then a=32, b=32: MUL -> 64; DIV -> 16.
- Overflow/wrap:
  - ADD 255+1 -> result=-256, overflow=1.
  - SUB -256-1 -> result=255, underflow=1.
  - MUL 255*255 -> s=4064, result=-32, overflow=1.
  - DIV -256/-1 -> result=0 (4096 wrapped), overflow=1.
- Rounding and divide by zero:
  - MUL -1*1 -> -1 (floor).
  - DIV -1/3 -> -5 (truncate toward zero).
  - DIV 8/0 -> result=0, overflow=1.
  - DIV 0/8 -> 0, flags 0.
- Random: 1000 random a, b over the full range [-256, 255], all four ops, checked against the reference model above one cycle later.
